// File: rtl/box_raster_drawer.sv
// box_raster_drawer
//   Accepts one axis-aligned box descriptor per valid/ready handshake and
//   walks it row-major, presenting one pixel per clock to vga_adapter.
//   Pixels that fall outside SCREEN_WIDTH x SCREEN_HEIGHT are stepped but not plotted.
//   Handshake: a box transfers on a rising clock edge where s_valid && s_ready.
//   s_ready is high only in IDLE. The descriptor is latched at the transfer
//   and stays fixed until the box completes.
//   Optional macro BOX_RASTER_OUTLINE_EN adds in_outline. When it is latched
//   high, only border pixels are plotted, and timing is unchanged.
module box_raster_drawer #(
    parameter logic [8:0] SCREEN_WIDTH  = 9'd160,
    parameter logic [8:0] SCREEN_HEIGHT = 9'd120,
    parameter int         COLOUR_W      = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [8:0]          in_box_x,
    input  logic [8:0]          in_box_y,
    input  logic [8:0]          in_box_w,
    input  logic [8:0]          in_box_h,
    input  logic [COLOUR_W-1:0] in_box_color,
`ifdef BOX_RASTER_OUTLINE_EN
    input  logic                in_outline,
`endif
    output logic [8:0]          vga_x,
    output logic [7:0]          vga_y,
    output logic                plot,
    output logic [COLOUR_W-1:0] colour,
    output logic                done
);

    typedef enum logic {S_IDLE = 1'b0, S_DRAW = 1'b1} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [8:0] r_x0, r_y0, r_w, r_h;
    logic [8:0] r_cx, r_cy;

    logic w_accept, w_empty, w_last_col, w_last_row;
    logic w_start, w_step, w_finish;

    // Pixel about to be registered: either the first pixel of a new box
    // (taken straight from the inputs) or the next pixel of the current one.
    logic [8:0] w_src_x0, w_src_y0, w_nxt_cx, w_nxt_cy;
    logic [9:0] w_px, w_py;
    logic       w_in_view, w_visible;

`ifdef BOX_RASTER_OUTLINE_EN
    logic       r_outline;
    logic       w_src_outline, w_border;
    logic [8:0] w_src_w, w_src_h;
`endif

    assign s_ready    = (r_state == S_IDLE);
    assign w_accept   = s_valid && s_ready;
    assign w_empty    = (in_box_w == 9'd0) || (in_box_h == 9'd0);
    assign w_last_col = (r_cx == r_w - 9'd1);
    assign w_last_row = (r_cy == r_h - 9'd1);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_empty) begin
                    w_state_nxt = S_DRAW;
                    w_start     = 1'b1;
                end
            end
            S_DRAW: begin
                if (w_last_col && w_last_row) begin
                    w_state_nxt = S_IDLE;
                    w_finish    = 1'b1;
                end else begin
                    w_step = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Select the coordinates of the pixel presented in the next cycle.
    always_comb begin
        w_src_x0 = r_x0;
        w_src_y0 = r_y0;
        w_nxt_cx = w_last_col ? 9'd0 : r_cx + 9'd1;
        w_nxt_cy = w_last_col ? r_cy + 9'd1 : r_cy;
        if (w_start) begin
            w_src_x0 = in_box_x;
            w_src_y0 = in_box_y;
            w_nxt_cx = 9'd0;
            w_nxt_cy = 9'd0;
        end
    end

    // Ten-bit sums so that a box hanging off the edge never wraps back on screen.
    assign w_px      = {1'b0, w_src_x0} + {1'b0, w_nxt_cx};
    assign w_py      = {1'b0, w_src_y0} + {1'b0, w_nxt_cy};
    assign w_in_view = (w_px < {1'b0, SCREEN_WIDTH}) && (w_py < {1'b0, SCREEN_HEIGHT});

`ifdef BOX_RASTER_OUTLINE_EN
    assign w_src_outline = w_start ? in_outline : r_outline;
    assign w_src_w       = w_start ? in_box_w   : r_w;
    assign w_src_h       = w_start ? in_box_h   : r_h;
    assign w_border      = (w_nxt_cx == 9'd0) || (w_nxt_cx == w_src_w - 9'd1) ||
                           (w_nxt_cy == 9'd0) || (w_nxt_cy == w_src_h - 9'd1);
    assign w_visible     = w_in_view && (!w_src_outline || w_border);
`else
    assign w_visible     = w_in_view;
`endif

    // Descriptor latch, raster counters and registered pixel outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x0   <= '0;
            r_y0   <= '0;
            r_w    <= '0;
            r_h    <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
            vga_x  <= '0;
            vga_y  <= '0;
            plot   <= 1'b0;
            colour <= '0;
            done   <= 1'b0;
        end else begin
            done <= (w_accept && w_empty) || w_finish;
            if (w_start) begin
                r_x0   <= in_box_x;
                r_y0   <= in_box_y;
                r_w    <= in_box_w;
                r_h    <= in_box_h;
                colour <= in_box_color;
            end
            if (w_start || w_step) begin
                r_cx  <= w_nxt_cx;
                r_cy  <= w_nxt_cy;
                vga_x <= w_px[8:0];
                vga_y <= w_py[7:0];
                plot  <= w_visible;
            end else begin
                plot  <= 1'b0;
            end
        end
    end

`ifdef BOX_RASTER_OUTLINE_EN
    // Outline mode bit travels with the descriptor.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     r_outline <= 1'b0;
        else if (w_start) r_outline <= in_outline;
    end
`endif

endmodule

// File: tb/tb_box_raster_drawer.sv
// Bench for box_raster_drawer. Expected pixels come from a behavioural
// raster model and are queued as {x[8:0], y[7:0], colour[2:0]}. They are
// popped when the DUT asserts plot. Timing, done and s_ready are checked
// inline in each scenario.
module tb_box_raster_drawer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [8:0] in_box_x = '0;
  logic [8:0] in_box_y = '0;
  logic [8:0] in_box_w = '0;
  logic [8:0] in_box_h = '0;
  logic [2:0] in_box_color = '0;
  logic       in_outline = 1'b0;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic       plot;
  logic [2:0] colour;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;

  box_raster_drawer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .in_box_x    (in_box_x),
    .in_box_y    (in_box_y),
    .in_box_w    (in_box_w),
    .in_box_h    (in_box_h),
    .in_box_color(in_box_color),
`ifdef BOX_RASTER_OUTLINE_EN
    .in_outline  (in_outline),
`endif
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .plot        (plot),
    .colour      (colour),
    .done        (done)
  );

  // clock / reset
  always #5 clock = ~clock;

  // scoreboard: every plotted pixel must match the head of the expected queue
  always @(negedge clock) begin
    if (reset_n && plot) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pixel_unexpected: got (%0d,%0d) c=%0d, required no plot", vga_x, vga_y, colour);
      end else begin
        mon_e = exp_q.pop_front();
        if ({vga_x, vga_y, colour} !== mon_e) begin
          n_err++;
          $display("FAIL pixel: got (%0d,%0d) c=%0d, required (%0d,%0d) c=%0d",
                   vga_x, vga_y, colour, mon_e[19:11], mon_e[10:3], mon_e[2:0]);
        end
      end
    end
  end

  // behavioural model: queue every pixel that should be plotted
  task automatic push_box(input int x, input int y, input int w, input int h,
                          input logic [2:0] c, input logic o);
    int px, py;
    logic [8:0] tx;
    logic [7:0] ty;
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        px = x + k;
        py = y + r;
        if (px < 160 && py < 120 && (!o || k == 0 || k == w - 1 || r == 0 || r == h - 1)) begin
          tx = px[8:0];
          ty = py[7:0];
          exp_q.push_back({tx, ty, c});
        end
      end
    end
  endtask

  // driver: present a descriptor for exactly one rising edge
  task automatic drive_box(input int x, input int y, input int w, input int h,
                           input logic [2:0] c, input logic o);
    in_box_x     = 9'(x);
    in_box_y     = 9'(y);
    in_box_w     = 9'(w);
    in_box_h     = 9'(h);
    in_box_color = c;
    in_outline   = o;
    s_valid      = 1'b1;
    @(posedge clock);
    #1;
    s_valid      = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({plot, done, s_ready, vga_x, vga_y, colour} !== {1'b0, 1'b0, 1'b1, 9'd0, 8'd0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_initial: got plot=%0b done=%0b rdy=%0b x=%0d y=%0d c=%0d, required 0 0 1 0 0 0",
               plot, done, s_ready, vga_x, vga_y, colour);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    push_box(5, 5, 5, 5, 3'd6, 1'b0);
    drive_box(5, 5, 5, 5, 3'd6, 1'b0);
    repeat (3) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({plot, done, s_ready, vga_x, vga_y} !== {1'b0, 1'b0, 1'b1, 9'd0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_midrun: got plot=%0b done=%0b rdy=%0b x=%0d y=%0d, required 0 0 1 0 0",
               plot, done, s_ready, vga_x, vga_y);
    end
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clock);
      n_cmp++;
      if ({done, plot, s_ready} !== 3'b001) begin
        n_err++;
        $display("FAIL reset_after: got done=%0b plot=%0b rdy=%0b, required 0 0 1", done, plot, s_ready);
      end
    end
  endtask

  task automatic test_basic();
    @(negedge clock);
    push_box(10, 20, 3, 2, 3'b101, 1'b0);
    drive_box(10, 20, 3, 2, 3'b101, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      n_cmp++;
      if ({s_ready, done, plot} !== 3'b001) begin
        n_err++;
        $display("FAIL basic_busy: cycle %0d got rdy=%0b done=%0b plot=%0b, required 0 0 1", k, s_ready, done, plot);
      end
    end
    @(negedge clock);
    n_cmp++;
    if ({done, s_ready, plot} !== 3'b110 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL basic_done: got done=%0b rdy=%0b plot=%0b left=%0d, required 1 1 0 0",
               done, s_ready, plot, exp_q.size());
    end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_pulse: got done=%0b, required 0", done);
    end
  endtask

  task automatic test_empty();
    @(negedge clock);
    drive_box(40, 40, 0, 4, 3'd2, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clock);
      n_cmp++;
      if ({done, s_ready, plot} !== {(k == 1), 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL empty: cycle %0d got done=%0b rdy=%0b plot=%0b, required %0b 1 0",
                 k, done, s_ready, plot, (k == 1));
      end
    end
  endtask

  task automatic test_clip();
    int nplot = 0;
    @(negedge clock);
    push_box(158, 119, 4, 2, 3'd3, 1'b0);
    drive_box(158, 119, 4, 2, 3'd3, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (plot) nplot++;
      n_cmp++;
      if (s_ready !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL clip_busy: cycle %0d got rdy=%0b done=%0b, required 0 0", k, s_ready, done);
      end
    end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b1 || nplot != 2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL clip_done: got done=%0b plots=%0d left=%0d, required 1 2 0", done, nplot, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int first_b = 0;
    @(negedge clock);
    push_box(30, 40, 2, 2, 3'd1, 1'b0);
    push_box(50, 60, 3, 1, 3'd6, 1'b0);
    drive_box(30, 40, 2, 2, 3'd1, 1'b0);
    in_box_x = 9'd50;
    in_box_y = 9'd60;
    in_box_w = 9'd3;
    in_box_h = 9'd1;
    in_box_color = 3'd6;
    s_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 6) s_valid = 1'b0;
      if (plot && colour == 3'd6 && first_b == 0) first_b = k;
      if (k == 5 || k == 9) begin
        n_cmp++;
        if (done !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_done: cycle %0d got done=%0b, required 1", k, done);
        end
      end
    end
    n_cmp++;
    if (first_b != 6 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_first_plot: got cycle %0d left=%0d, required cycle 6 left 0", first_b, exp_q.size());
    end
  endtask

`ifdef BOX_RASTER_OUTLINE_EN
  task automatic test_outline();
    int nplot = 0;
    @(negedge clock);
    push_box(0, 0, 4, 3, 3'd7, 1'b1);
    drive_box(0, 0, 4, 3, 3'd7, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (plot) nplot++;
      if (k == 6 || k == 7) begin
        n_cmp++;
        if (plot !== 1'b0) begin
          n_err++;
          $display("FAIL outline_interior: cycle %0d got plot=%0b, required 0", k, plot);
        end
      end
    end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b1 || nplot != 10) begin
      n_err++;
      $display("FAIL outline_done: got done=%0b plots=%0d, required 1 10", done, nplot);
    end
  endtask
`endif

  task automatic test_random();
    int x, y, w, h, n, nexp, nplot;
    logic [2:0] c;
    for (int b = 0; b < 6; b++) begin
      x = $urandom_range(150, 165);
      y = $urandom_range(110, 125);
      w = $urandom_range(0, 5);
      h = $urandom_range(0, 4);
      c = 3'($urandom_range(0, 7));
      n = w * h;
      nplot = 0;
      @(negedge clock);
      n_cmp++;
      if (s_ready !== 1'b1) begin
        n_err++;
        $display("FAIL rand_ready: box %0d got rdy=%0b, required 1", b, s_ready);
      end
      push_box(x, y, w, h, c, 1'b0);
      nexp = exp_q.size();
      drive_box(x, y, w, h, c, 1'b0);
      for (int k = 1; k <= n; k++) begin
        @(negedge clock);
        if (plot) nplot++;
      end
      @(negedge clock);
      n_cmp++;
      if (done !== 1'b1 || s_ready !== 1'b1 || nplot != nexp) begin
        n_err++;
        $display("FAIL rand_box: box %0d (%0d,%0d,%0dx%0d) got done=%0b rdy=%0b plots=%0d, required 1 1 %0d",
                 b, x, y, w, h, done, s_ready, nplot, nexp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_clip();
    test_back_to_back();
`ifdef BOX_RASTER_OUTLINE_EN
    test_outline();
`endif
    test_random();
    @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_queue: got %0d pixels outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
